systolic_feeder: RTL

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/sa_pkg.sv | 16 +
 rtl/skew_line.sv | 49 ++++
 rtl/systolic_feeder.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/sa_pkg.sv
// Shared systolic-array constants and the feeder FSM state type.
package sa_pkg;

    localparam int unsigned SA_N         = 4;   // PE array dimension / lane count
    localparam int unsigned SA_DW        = 8;   // operand byte width
    localparam int unsigned SA_K         = 16;  // inner dimension, reads per tile
    localparam int unsigned SA_NUM_TILES = 32;  // A row-blocks per run
    localparam int unsigned SA_AW        = 9;   // SRAM word address width

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StFlush
    } state_e;

endpackage

// File: rtl/skew_line.sv
// Fixed-depth delay line for one operand lane; data is forced to 0 whenever valid is low.
module skew_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] in_data,
    input  logic          in_vld,
    output logic [DW-1:0] out_data,
    output logic          out_vld
);

    logic [DW-1:0] in_gated;

    assign in_gated = in_vld ? in_data : '0;

    if (DEPTH == 0) begin : g_pass
        logic unused_clk_rst;

        assign unused_clk_rst = clk ^ rst_n;
        assign out_data       = in_gated;
        assign out_vld        = in_vld;
    end else begin : g_pipe
        logic [DW-1:0]    data_q [DEPTH];
        logic [DEPTH-1:0] vld_q;

        // Shift data and valid one stage per cycle.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) begin
                    data_q[i] <= '0;
                    vld_q[i]  <= 1'b0;
                end
            end else begin
                data_q[0] <= in_gated;
                vld_q[0]  <= in_vld;
                for (int i = 1; i < DEPTH; i++) begin
                    data_q[i] <= data_q[i-1];
                    vld_q[i]  <= vld_q[i-1];
                end
            end
        end

        assign out_data = data_q[DEPTH-1];
        assign out_vld  = vld_q[DEPTH-1];
    end

endmodule

// File: rtl/systolic_feeder.sv
// Streams K A/B words per tile out of SRAM and skews them onto the PE array edges.
module systolic_feeder
    import sa_pkg::*;
#(
    parameter int unsigned N         = SA_N,
    parameter int unsigned DW        = SA_DW,
    parameter int unsigned K         = SA_K,
    parameter int unsigned NUM_TILES = SA_NUM_TILES,
    parameter int unsigned AW        = SA_AW,
    localparam int unsigned TW       = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            a_rd_en,
    output logic [AW-1:0]   a_addr,
    input  logic [N*DW-1:0] a_rdata,
    output logic            b_rd_en,
    output logic [AW-1:0]   b_addr,
    input  logic [N*DW-1:0] b_rdata,
    output logic [N*DW-1:0] pe_a,
    output logic [N*DW-1:0] pe_b,
    output logic [N-1:0]    pe_a_vld,
    output logic [N-1:0]    pe_b_vld,
    output logic            acc_clr,
    output logic [TW-1:0]   tile_idx
);

    // One counter serves both the K fetch cycles and the 2N-1 flush cycles.
    localparam int unsigned MAXC = (K > 2 * N) ? K : 2 * N;
    localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] FETCH_LAST = CW'(K - 1);
    localparam logic [CW-1:0] FLUSH_LAST = CW'(2 * N - 2);
    localparam logic [TW-1:0] TILE_LAST  = TW'(NUM_TILES - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tile_q, tile_d;
    logic [AW-1:0] a_cnt_q, a_cnt_d;
    logic          rd_q;
    logic          clr_q;
    logic          done_q;
    logic          fetch;

    assign fetch = (state_q == StFetch);

    // Next-state: FETCH K cycles, FLUSH 2N-1 cycles, repeat per tile.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tile_d  = tile_q;
        a_cnt_d = a_cnt_q;
        unique case (state_q)
            StIdle: begin
                // A start coinciding with done is dropped.
                if (start && !done_q) begin
                    state_d = StFetch;
                    cnt_d   = '0;
                    tile_d  = '0;
                    a_cnt_d = '0;
                end
            end
            StFetch: begin
                a_cnt_d = a_cnt_q + 1'b1;
                if (cnt_q == FETCH_LAST) begin
                    state_d = StFlush;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StFlush: begin
                if (cnt_q == FLUSH_LAST) begin
                    cnt_d = '0;
                    if (tile_q == TILE_LAST) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StFetch;
                        tile_d  = tile_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, counters and the one-cycle-late read/clear/done flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            tile_q  <= '0;
            a_cnt_q <= '0;
            rd_q    <= 1'b0;
            clr_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tile_q  <= tile_d;
            a_cnt_q <= a_cnt_d;
            rd_q    <= fetch;
            clr_q   <= fetch && (cnt_q == '0);
            done_q  <= (state_q == StFlush) && (cnt_q == FLUSH_LAST) && (tile_q == TILE_LAST);
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign a_rd_en  = fetch;
    assign b_rd_en  = fetch;
    assign a_addr   = fetch ? a_cnt_q : '0;
    assign b_addr   = fetch ? AW'(cnt_q) : '0;
    assign acc_clr  = clr_q;
    assign tile_idx = tile_q;

    // rdata lands one cycle after the read, so rd_q marks it valid; lane i adds i cycles.
    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_line #(
            .DEPTH(i),
            .DW   (DW)
        ) u_skew_a (
            .clk     (clk),
            .rst_n   (rst_n),
            .in_data (a_rdata[i*DW +: DW]),
            .in_vld  (rd_q),
            .out_data(pe_a[i*DW +: DW]),
            .out_vld (pe_a_vld[i])
        );

        skew_line #(
            .DEPTH(i),
            .DW   (DW)
        ) u_skew_b (
            .clk     (clk),
            .rst_n   (rst_n),
            .in_data (b_rdata[i*DW +: DW]),
            .in_vld  (rd_q),
            .out_data(pe_b[i*DW +: DW]),
            .out_vld (pe_b_vld[i])
        );
    end

endmodule
